// File: rtl/kulisch_pkg.sv
// Shared types and width helpers for the sequential Kulisch accumulator.
// Format presets give (EWIDTH, MWIDTH) for the supported source formats.
package kulisch_pkg;

    typedef enum logic [1:0] {
        ACC     = 2'd0,
        RESOLVE = 2'd1,
        OUT     = 2'd2
    } state_t;

    localparam int FP16_EWIDTH = 5;
    localparam int FP16_MWIDTH = 10;
    localparam int BF16_EWIDTH = 8;
    localparam int BF16_MWIDTH = 7;

    function automatic int pwidth(input int mwidth);
        return 2 * mwidth + 2;
    endfunction

    // One bit for the exponent sign extension, one for the offset add.
    function automatic int shift_width(input int ewidth);
        return ewidth + 2;
    endfunction

endpackage

// File: rtl/kulisch_align.sv
// Per-lane alignment: sign-extend sum/carry words to the accumulator width and shift by exp+offset.
// With KACC_OVF_DETECT_EN defined, too_high flags a lane shifted past the top of the accumulator.
module kulisch_align
    import kulisch_pkg::*;
#(
    parameter int EWIDTH    = 5,
    parameter int PWIDTH    = 22,
    parameter int AWIDTH    = 92,
    parameter int SHIFT_OFS = 28
) (
    input  logic [PWIDTH-1:0] sum_word,
    input  logic [PWIDTH-1:0] carry_word,
    input  logic [EWIDTH:0]   exp_word,
    output logic [AWIDTH-1:0] sum_al,
    output logic [AWIDTH-1:0] carry_al
`ifdef KACC_OVF_DETECT_EN
    ,
    output logic              too_high
`endif
);

    localparam int SW = shift_width(EWIDTH);

    logic signed [SW-1:0] shift;
    logic [SW-1:0]        amt;
    logic                 below;
    logic                 above;
    logic                 drop;

    assign shift = signed'({exp_word[EWIDTH], exp_word}) + SW'(SHIFT_OFS);
    assign amt   = shift;
    assign below = shift[SW-1];
    assign above = !below && (int'(shift) > AWIDTH - PWIDTH);
    assign drop  = below || above;

    assign sum_al   = drop ? '0 : ({{(AWIDTH-PWIDTH){sum_word[PWIDTH-1]}}, sum_word} << amt);
    assign carry_al = drop ? '0 : ({{(AWIDTH-PWIDTH){carry_word[PWIDTH-1]}}, carry_word} << amt);

`ifdef KACC_OVF_DETECT_EN
    assign too_high = above;
`endif

endmodule

// File: rtl/kulisch_acc_seq.sv
// Sequential carry-save Kulisch accumulator with a chunked, multi-cycle final carry-propagate.
// Optional KACC_OVF_DETECT_EN adds the sticky o_ovf flag.
// state   | meaning
// ACC     | accepting beats into the carry-save register
// RESOLVE | carry-propagate one CHUNK per cycle, LSB chunk first
// OUT     | resolved result held until the downstream takes it
module kulisch_acc_seq
    import kulisch_pkg::*;
#(
    parameter int NUM       = 4,
    parameter int EWIDTH    = FP16_EWIDTH,
    parameter int MWIDTH    = FP16_MWIDTH,
    parameter int AWIDTH    = 92,
    parameter int SHIFT_OFS = 28,
    parameter int CHUNK     = 23,
    localparam int PWIDTH   = pwidth(MWIDTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_valid,
    output logic                      i_ready,
    input  logic                      i_first,
    input  logic                      i_last,
    input  logic [NUM*PWIDTH-1:0]     i_sum_mul,
    input  logic [NUM*PWIDTH-1:0]     i_carry_mul,
    input  logic [NUM*(EWIDTH+1)-1:0] i_exp_mul,
    output logic                      o_valid,
    input  logic                      o_ready,
    output logic [AWIDTH-1:0]         o_acc
`ifdef KACC_OVF_DETECT_EN
    ,
    output logic                      o_ovf
`endif
);

    localparam int NCH = AWIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    state_t            state, state_nxt;
    logic [AWIDTH-1:0] acc_sum, acc_carry, res;
    logic [AWIDTH-1:0] tree_sum, tree_carry;
    logic [AWIDTH-1:0] lane_sum   [NUM];
    logic [AWIDTH-1:0] lane_carry [NUM];
    logic [CHUNK:0]    chunk_add;
    logic [CW-1:0]     rem;
    logic              cy;
    logic              accept;

`ifdef KACC_OVF_DETECT_EN
    logic [NUM-1:0]    lane_hi;
    logic              ovf_q;
    logic              msb_cin;
`endif

    for (genvar g = 0; g < NUM; g++) begin : g_lane
        kulisch_align #(
            .EWIDTH   (EWIDTH),
            .PWIDTH   (PWIDTH),
            .AWIDTH   (AWIDTH),
            .SHIFT_OFS(SHIFT_OFS)
        ) u_align (
            .sum_word  (i_sum_mul[g*PWIDTH +: PWIDTH]),
            .carry_word(i_carry_mul[g*PWIDTH +: PWIDTH]),
            .exp_word  (i_exp_mul[g*(EWIDTH+1) +: EWIDTH+1]),
            .sum_al    (lane_sum[g]),
            .carry_al  (lane_carry[g])
`ifdef KACC_OVF_DETECT_EN
            ,
            .too_high  (lane_hi[g])
`endif
        );
    end

    // 3:2 compressor reduction: each step folds one more lane word into the sum/carry pair.
    always_comb begin
        logic [AWIDTH-1:0] s, c, t, maj;
        s = i_first ? '0 : acc_sum;
        c = i_first ? '0 : acc_carry;
        for (int k = 0; k < NUM; k++) begin
            t   = lane_sum[k];
            maj = (s & c) | (s & t) | (c & t);
            s   = s ^ c ^ t;
            c   = maj << 1;
            t   = lane_carry[k];
            maj = (s & c) | (s & t) | (c & t);
            s   = s ^ c ^ t;
            c   = maj << 1;
        end
        tree_sum   = s;
        tree_carry = c;
    end

    assign chunk_add = {1'b0, acc_sum[CHUNK-1:0]} + {1'b0, acc_carry[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, cy};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ACC;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        i_ready   = 1'b0;
        o_valid   = 1'b0;
        case (state)
            ACC: begin
                i_ready = 1'b1;
                if (i_valid && i_last) state_nxt = RESOLVE;
            end
            RESOLVE: begin
                if (rem == '0) state_nxt = OUT;
            end
            OUT: begin
                o_valid = 1'b1;
                if (o_ready) state_nxt = ACC;
            end
            default: state_nxt = ACC;
        endcase
    end

    assign accept = i_valid && i_ready;
    assign o_acc  = o_valid ? res : '0;

    // Resolve streams the chunks out of the bottom of acc_sum/acc_carry and into the top of res.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_sum   <= '0;
            acc_carry <= '0;
            res       <= '0;
            cy        <= 1'b0;
            rem       <= '0;
        end else begin
            case (state)
                ACC: begin
                    if (accept) begin
                        acc_sum   <= tree_sum;
                        acc_carry <= tree_carry;
                        cy        <= 1'b0;
                        rem       <= CW'(NCH - 1);
                    end
                end
                RESOLVE: begin
                    res       <= (res >> CHUNK) | (AWIDTH'(chunk_add[CHUNK-1:0]) << (AWIDTH - CHUNK));
                    acc_sum   <= acc_sum >> CHUNK;
                    acc_carry <= acc_carry >> CHUNK;
                    cy        <= chunk_add[CHUNK];
                    if (rem != '0) rem <= rem - CW'(1);
                end
                OUT: begin
                    if (o_ready) begin
                        acc_sum   <= '0;
                        acc_carry <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef KACC_OVF_DETECT_EN
    assign msb_cin = chunk_add[CHUNK-1] ^ acc_sum[CHUNK-1] ^ acc_carry[CHUNK-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (accept) ovf_q <= (i_first ? 1'b0 : ovf_q) | (|lane_hi);
                end
                RESOLVE: begin
                    if (rem == '0) ovf_q <= ovf_q | (msb_cin ^ chunk_add[CHUNK]);
                end
                OUT: begin
                    if (o_ready) ovf_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_ovf = ovf_q;
`endif

endmodule
